// File: rtl/macc_op_sequencer_pkg.sv
// rtl/macc_op_sequencer_pkg.sv - states and opcode selection for the macc op sequencer
package macc_op_sequencer_pkg;
  `include "macc_defines.vh"

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // First element seeds the accumulator (optionally with bias); the rest accumulate.
  function automatic logic [OP_CODE_WIDTH-1:0] issue_op(input logic first,
                                                        input logic square,
                                                        input logic add);
    logic [OP_CODE_WIDTH-1:0] op;
    if (!first)   op = square ? OP_SQ_ACC : OP_MUL_ACC;
    else if (add) op = square ? OP_SQ_ADD : OP_MUL_ADD;
    else          op = square ? OP_SQ     : OP_MUL;
    return op;
  endfunction
endpackage

// File: rtl/macc_defines.vh
// rtl/macc_defines.vh - opcode encodings shared by the sequencer and the macc primitive
localparam int         OP_CODE_WIDTH = 3;
localparam logic [2:0] OP_MUL        = 3'b000;
localparam logic [2:0] OP_MUL_ACC    = 3'b010;
localparam logic [2:0] OP_MUL_ADD    = 3'b100;
localparam logic [2:0] OP_SQ         = 3'b001;
localparam logic [2:0] OP_SQ_ACC     = 3'b011;
localparam logic [2:0] OP_SQ_ADD     = 3'b101;

// File: rtl/macc_issue_reg.sv
// rtl/macc_issue_reg.sv - single-entry valid/ready pipeline register, full throughput
module macc_issue_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  // Refill is allowed in the same cycle the held beat drains.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/macc_op_sequencer.sv
// rtl/macc_op_sequencer.sv - turns an operand stream into per-element macc opcodes for one vector
module macc_op_sequencer
  import macc_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [LEN_W-1:0]         vec_len,
  input  logic                     square_mode,
  input  logic                     add_mode,
  input  logic [DATA_W-1:0]        bias,
  input  logic [DATA_W-1:0]        op_a,
  input  logic [DATA_W-1:0]        op_b,
  input  logic                     op_valid,
  output logic                     op_ready,
  output logic [DATA_W-1:0]        macc_a,
  output logic [DATA_W-1:0]        macc_b,
  output logic [DATA_W-1:0]        macc_c,
  output logic [OP_CODE_WIDTH-1:0] macc_op,
  output logic                     macc_valid,
  output logic                     macc_last,
  input  logic                     macc_ready,
  output logic                     busy,
  output logic                     done
);
  localparam int BEAT_W = 3 * DATA_W + OP_CODE_WIDTH + 1;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q;
  logic               square_q, add_q;
  logic [DATA_W-1:0]  bias_q;
  logic               done_q, done_d;
  logic               load_cfg;
  logic               accept;
  logic               stage_ready;
  logic               first_el, last_el;
  logic [BEAT_W-1:0]  beat_in, beat_out;

  assign first_el = (cnt_q == '0);
  assign last_el  = (cnt_q == len_q - LEN_W'(1));
  assign accept   = op_valid && op_ready;

  assign beat_in = {op_a,
                    square_q ? {DATA_W{1'b0}} : op_b,
                    (first_el && add_q) ? bias_q : {DATA_W{1'b0}},
                    issue_op(first_el, square_q, add_q),
                    last_el};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load_cfg = 1'b0;
    op_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start landing on the done cycle belongs to the vector just finished.
        if (start && !done_q) begin
          if (vec_len == '0) begin
            done_d = 1'b1;
          end else begin
            load_cfg = 1'b1;
            cnt_d    = '0;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        op_ready = (cnt_q != len_q) && stage_ready;
        if (op_valid && (cnt_q != len_q) && stage_ready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_el) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (macc_valid && macc_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q    <= '0;
      square_q <= 1'b0;
      add_q    <= 1'b0;
      bias_q   <= '0;
    end else if (load_cfg) begin
      len_q    <= vec_len;
      square_q <= square_mode;
      add_q    <= add_mode;
      bias_q   <= bias;
    end
  end

  macc_issue_reg #(.WIDTH(BEAT_W)) u_issue (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (accept),
    .in_ready (stage_ready),
    .in_data  (beat_in),
    .out_valid(macc_valid),
    .out_ready(macc_ready),
    .out_data (beat_out)
  );

  assign {macc_a, macc_b, macc_c, macc_op, macc_last} = beat_out;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_macc_op_sequencer.sv
// tb/tb_macc_op_sequencer.sv - randomized directed bench with a behavioural vector model
module tb_macc_op_sequencer;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  vec_len = '0;
  logic              square_mode = 1'b0, add_mode = 1'b0;
  logic [DATA_W-1:0] bias = '0, op_a = '0, op_b = '0;
  logic              op_valid = 1'b0, op_ready;
  logic [DATA_W-1:0] macc_a, macc_b, macc_c;
  logic [2:0]        macc_op;
  logic              macc_valid, macc_last;
  logic              macc_ready = 1'b0;
  logic              busy, done;

  macc_op_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .vec_len(vec_len),
    .square_mode(square_mode), .add_mode(add_mode), .bias(bias),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .macc_a(macc_a), .macc_b(macc_b), .macc_c(macc_c), .macc_op(macc_op),
    .macc_valid(macc_valid), .macc_last(macc_last), .macc_ready(macc_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0, passes = 0, fails = 0;
  logic [DATA_W-1:0] va [16];
  logic [DATA_W-1:0] vb [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_outs"}, {op_ready, macc_a, macc_b, macc_c, macc_op, macc_valid, macc_last, busy, done}, 64'd0);
  endtask

  // Model: expected opcode from the opcode table.
  function automatic logic [2:0] model_op(input int i, input logic sq, input logic add);
    if (i != 0) return sq ? 3'b011 : 3'b010;
    if (add)    return sq ? 3'b101 : 3'b100;
    return sq ? 3'b001 : 3'b000;
  endfunction

  // rmode: 0 always ready, 1 toggling, 2 random
  task automatic run_vector(input int len, input logic sq, input logic add,
                            input logic [DATA_W-1:0] bv, input int rmode,
                            input bit gaps, input bit spurious, input string tag);
    int idx = 0, k = 0, cyc = 0, first_hs = -1, last_hs = -1;
    bit finished = 0, done_pending = 0, held = 0;
    logic [DATA_W*3+4-1:0] saved;
    logic [DATA_W-1:0] ea, eb, ec;
    @(negedge clk);
    vec_len = LEN_W'(len); square_mode = sq; add_mode = add; bias = bv; start = 1'b1;
    op_valid = 1'b0; macc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check({tag, "_busy_after_start"}, busy, 1);
    while (!finished && cyc < 300) begin
      if (cyc != 0) @(negedge clk);
      start       = spurious ? ($urandom_range(0, 2) == 0) : 1'b0;
      vec_len     = LEN_W'($urandom);
      square_mode = $urandom_range(0, 1);
      add_mode    = $urandom_range(0, 1);
      bias        = DATA_W'($urandom);
      op_valid    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      op_a        = (idx < len) ? va[idx] : DATA_W'($urandom);
      op_b        = (idx < len) ? vb[idx] : DATA_W'($urandom);
      macc_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (done_pending) begin
        check({tag, "_done"}, {done, busy, macc_valid}, 3'b100);
        finished = 1;
      end else if (done) begin
        check({tag, "_early_done"}, done, 0);
      end
      if (held)
        check({tag, "_stable"}, {macc_a, macc_b, macc_c, macc_op, macc_last}, saved);
      if (idx == len)
        check({tag, "_no_accept_after_len"}, op_ready, 0);
      if (op_valid && op_ready) idx++;
      held = 0;
      if (macc_valid && !finished) begin
        if (macc_ready) begin
          if (k < len) begin
            ea = va[k];
            eb = sq ? '0 : vb[k];
            ec = (k == 0 && add) ? bv : '0;
            check($sformatf("%s_beat%0d", tag, k), {macc_a, macc_b, macc_c, macc_op, macc_last},
                  {ea, eb, ec, model_op(k, sq, add), (k == len - 1)});
          end else begin
            check({tag, "_extra_beat"}, k, len);
          end
          if (k == 0) first_hs = cyc;
          if (k == len - 1) begin last_hs = cyc; done_pending = 1; end
          k++;
        end else begin
          held  = 1;
          saved = {macc_a, macc_b, macc_c, macc_op, macc_last};
        end
      end
      cyc++;
    end
    check({tag, "_completed"}, finished, 1);
    check({tag, "_beat_count"}, k, len);
    if (rmode == 0 && !gaps)
      check({tag, "_throughput"}, last_hs - first_hs, len - 1);
    @(negedge clk);
    start = 1'b0; op_valid = 1'b0;
    #1 check({tag, "_idle_after"}, {done, busy, macc_valid}, 3'b000);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      va[i] = DATA_W'($urandom);
      vb[i] = DATA_W'($urandom);
    end
  endtask

  initial begin
    int hs;
    #1 check_all_clear("reset");
    @(negedge clk); resetn = 1'b1;
    #1 check_all_clear("post_reset");

    for (int i = 0; i < 4; i++) begin va[i] = DATA_W'(i + 1); vb[i] = 16'd2; end
    run_vector(4, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, "mul_acc");

    fill_random();
    run_vector(3, 1'b1, 1'b1, 16'h0010, 0, 1'b0, 1'b0, "sq_bias");

    fill_random();
    run_vector(6, 1'b0, 1'b1, 16'h1234, 1, 1'b1, 1'b0, "backpressure");

    // zero length: done next cycle, no beat
    @(negedge clk);
    vec_len = '0; start = 1'b1; macc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check("zero_len_done", {done, busy, macc_valid}, 3'b100);
    @(negedge clk);
    #1 check("zero_len_after", {done, busy, macc_valid}, 3'b000);

    fill_random();
    run_vector(5, 1'b0, 1'b0, 16'h0000, 2, 1'b1, 1'b1, "ignored_start");

    fill_random();
    run_vector(15, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0, "max_len");

    // reset in the middle of a 5-beat vector
    fill_random();
    @(negedge clk);
    vec_len = 4'd5; square_mode = 1'b0; add_mode = 1'b0; start = 1'b1;
    op_valid = 1'b1; macc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      if (c != 0) @(negedge clk);
      op_a = va[c % 16]; op_b = vb[c % 16];
      #1 if (macc_valid && macc_ready) hs++;
    end
    check("mid_reset_two_beats", hs, 2);
    @(negedge clk);
    #1 check("mid_reset_still_busy", busy, 1);
    resetn = 1'b0;
    #1 check_all_clear("mid_reset");
    @(negedge clk);
    op_valid = 1'b0;
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 check("mid_reset_no_done", {done, busy, macc_valid}, 3'b000);
    end

    for (int v = 0; v < 4; v++) begin
      fill_random();
      run_vector($urandom_range(1, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DATA_W'($urandom), 2, 1'b1, 1'b1, $sformatf("rand%0d", v));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/macc_op_sequencer.md
Name: macc_op_sequencer

Overview:
- Upstream feeder for the macc primitive; turns an operand stream into a per-element macc opcode stream for one dot product (or sum of squares) of programmable length.
- First element issues MULTIPLY / MULTIPLY-ADD / SQUARE / SQUARE-ADD. Every later element issues the -ACC variant.
- Registered valid/ready output stage with back-pressure; one element per cycle sustained.

Parameters:
- DATA_W, 16, operand width (a, b, bias), fixed point, passed through unchanged.
- LEN_W, 10, width of vector-length field; max length 2^LEN_W-1.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches cfg and begins a vector (honoured only in IDLE)
- vec_len  input  LEN_W  number of elements, sampled on start
- square_mode  input  1  1 = SQUARE family (op[0]=1), sampled on start
- add_mode  input  1  1 = first op is the ADD variant using bias, sampled on start
- bias  input  DATA_W  addend for first element, sampled on start
- op_a  input  DATA_W  operand a
- op_b  input  DATA_W  operand b (ignored in square_mode)
- op_valid  input  1  operand pair valid
- op_ready  output  1  operand pair accepted when op_valid & op_ready
- macc_a  output  DATA_W  to macc
- macc_b  output  DATA_W  to macc; forced 0 in square_mode
- macc_c  output  DATA_W  bias on first element, 0 otherwise
- macc_op  output  3  opcode: 000 MUL, 010 MUL-ACC, 100 MUL-ADD, 001 SQ, 011 SQ-ACC, 101 SQ-ADD
- macc_valid  output  1  output beat valid
- macc_last  output  1  marks final element of vector
- macc_ready  input  1  macc accepts beat
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse when the vector is complete

Behaviour:
- Reset (async assert, sync-deasserted by system): state IDLE, counter 0. All outputs 0: op_ready, macc_*, busy, done.
- Reset mid-vector: the partial vector is discarded; no done pulse is produced.
- FSM IDLE:
  - op_ready=0.
  - start with vec_len>0: latch cfg, cnt<=0, go RUN, busy=1 next cycle.
  - start with vec_len==0: stay IDLE, busy stays 0, done=1 the next cycle, no beat issued.
- FSM RUN:
  - op_ready = counter not exhausted & (!macc_valid | macc_ready).
  - On op accept: output register loads next cycle (latency 1).
  - Opcode for the accepted element: {add_mode & first, ~first, square_mode}, where first=(cnt==0).
  - macc_last=1 when cnt==len-1. cnt increments.
  - After the last element is accepted, op_ready=0 and the block moves to DRAIN.
- FSM DRAIN:
  - Hold the output until macc_valid & macc_ready on the last beat.
  - done=1 for exactly one cycle, aligned to the cycle after that handshake. busy=0 in that same cycle. Go IDLE.
- Output stage rules:
  - macc_valid, once asserted, holds and all macc_* are stable until macc_ready.
  - Simultaneous drain and refill in the same cycle sustains 1 beat/cycle.
- start ignored while busy (RUN/DRAIN); cfg is not changed.
- start coincident with done: ignored, because done is an IDLE-entry cycle.
- op_valid in IDLE/DRAIN: not accepted, with no side effects.
- vec_len = 2^LEN_W-1 must complete; the counter never wraps within a vector.
- macc_c = 0 on all non-first beats, and on the first beat when add_mode=0.

Decomposition:
- Shared include macc_defines.vh holds the opcode localparams (OP_MUL, OP_MUL_ACC, OP_MUL_ADD, OP_SQ, OP_SQ_ACC, OP_SQ_ADD) and OP_CODE_WIDTH=3. The macc block uses the same file.
- Sub-module macc_issue_reg: generic valid/ready pipeline register, width = 3*DATA_W+3+1, async active-low reset.
- FSM and counter stay in the top.

Test Plan:
- Check after reset: all outputs 0 and op_ready=0. Also: resetn low mid-RUN (after 2 of 5 beats) -> outputs clear immediately, no done, next start works normally.
- Basic MUL-ACC: vec_len=4, square_mode=0, add_mode=0, a=1..4, b=2, macc_ready=1 -> ops 000,010,010,010; macc_c all 0; last on the 4th beat; done exactly 1 cycle after the 4th handshake; 1 beat/cycle.
- Square with bias: vec_len=3, square_mode=1, add_mode=1, bias=0x0010 -> ops 101,011,011; macc_b=0 on all beats; macc_c=0x0010 only on beat 0.
- Back-pressure: vec_len=6, macc_ready toggling 1010... plus random op_valid gaps -> each macc_* held stable while !macc_ready; all 6 operands appear in order with no loss or duplication.
- Zero length and ignored start: vec_len=0 start -> done next cycle, no macc_valid. A second start while busy with vec_len=5 -> ignored, original length kept.
- Max length: LEN_W=4, vec_len=15 -> 15 beats, last only on the 15th, no wrap.
